swipt_dpll_gen2: RTL and testbench

Parametrised second-generation digital PLL for the SWIPT link. It takes a 1-bit reference (the comparator or heartbeat-derived pll_in), tracks it with an NCO phase accumulator driven by a PI loop filter, and reports phase, frequency word, NCO output and lock status. It generalises the first-generation PLL with configurable widths, separate P/I shift coefficients, frequency clamping, an input synchroniser and a lock/timeout detector.

---
 rtl/swipt_dpll_gen2.sv | 147 ++++++++++++++
 tb/tb_swipt_dpll_gen2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/swipt_dpll_gen2.sv
// Second-generation SWIPT digital PLL: synchronised reference, NCO and clamped PI loop filter.
// Define SWIPT_DPLL_LOCK_EN to build the lock/timeout detector; otherwise locked is tied low.
module swipt_dpll_gen2 #(
    parameter int unsigned         PHASE_W  = 32,
    parameter int unsigned         LG_W     = 5,
    parameter logic [PHASE_W-1:0]  FREQ_MIN = 32'h0000_0020,
    parameter logic [PHASE_W-1:0]  FREQ_MAX = 32'h0010_0000,
    parameter logic [PHASE_W-1:0]  LOCK_TH  = 32'h0100_0000,
    parameter int unsigned         LOCK_N   = 16,
    parameter int unsigned         TIMEOUT  = 4096
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enable,
    input  logic               load_freq,
    input  logic [PHASE_W-1:0] freq_init,
    input  logic [LG_W-1:0]    lg_p,
    input  logic [LG_W-1:0]    lg_i,
    input  logic               pll_in,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] freq,
    output logic [1:0]         error,
    output logic               edge_valid,
    output logic               locked
);

    localparam int unsigned EXT_W = PHASE_W + 2;
    localparam logic signed [EXT_W-1:0] MIN_EXT = {2'b00, FREQ_MIN};
    localparam logic signed [EXT_W-1:0] MAX_EXT = {2'b00, FREQ_MAX};

    logic               s1_q, s2_q, s3_q;
    logic [PHASE_W-1:0] phase_q, freq_q, integ_q;
    logic               lag_q, edge_valid_q;

    logic               rise, edge_go;
    logic signed [EXT_W-1:0] err_ext, integ_ext, integ_n, freq_n;

    function automatic logic [PHASE_W-1:0] clamp(input logic signed [EXT_W-1:0] v);
        if (v < MIN_EXT) begin
            return FREQ_MIN;
        end else if (v > MAX_EXT) begin
            return FREQ_MAX;
        end
        return v[PHASE_W-1:0];
    endfunction

    assign rise    = s2_q & ~s3_q;
    // load_freq discards a coincident edge; a frozen loop processes none
    assign edge_go = rise & enable & ~load_freq;

    // Wide signed datapath so integ + P + I never wraps before clamping
    always_comb begin
        err_ext   = {{2{phase_q[PHASE_W-1]}}, phase_q};
        integ_ext = {2'b00, integ_q};
        integ_n   = integ_ext + (err_ext >>> lg_i);
        freq_n    = integ_n + (err_ext >>> lg_p);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            phase_q      <= '0;
            freq_q       <= freq_init;
            integ_q      <= freq_init;
            lag_q        <= 1'b0;
            edge_valid_q <= 1'b0;
        end else begin
            s1_q         <= pll_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            edge_valid_q <= edge_go;
            if (enable) begin
                phase_q <= phase_q + freq_q;
            end
            if (load_freq) begin
                freq_q  <= freq_init;
                integ_q <= freq_init;
            end else if (edge_go) begin
                freq_q  <= clamp(freq_n);
                integ_q <= clamp(integ_n);
                lag_q   <= phase_q[PHASE_W-1];
            end
        end
    end

    assign phase      = phase_q;
    assign freq       = freq_q;
    assign error      = {lag_q, phase_q[PHASE_W-1]};
    assign edge_valid = edge_valid_q;

`ifdef SWIPT_DPLL_LOCK_EN
    localparam int unsigned LCNT_W = $clog2(LOCK_N + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PHASE_W-1:0] MOST_NEG = {1'b1, {(PHASE_W-1){1'b0}}};

    logic [LCNT_W-1:0]  lock_cnt_q;
    logic [TCNT_W-1:0]  to_cnt_q;
    logic               locked_q;
    logic [PHASE_W-1:0] err_abs;
    logic               in_win, to_expire;

    always_comb begin
        err_abs   = phase_q[PHASE_W-1] ? (~phase_q + PHASE_W'(1)) : phase_q;
        in_win    = (phase_q != MOST_NEG) && (err_abs < LOCK_TH);
        // Counter is at, or about to reach, the timeout with no edge to restart it
        to_expire = !rise && ((to_cnt_q == TCNT_W'(TIMEOUT)) ||
                              (enable && to_cnt_q == TCNT_W'(TIMEOUT - 1)));
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            lock_cnt_q <= '0;
            to_cnt_q   <= '0;
            locked_q   <= 1'b0;
        end else begin
            if (rise) begin
                to_cnt_q <= '0;
            end else if (enable && to_cnt_q != TCNT_W'(TIMEOUT)) begin
                to_cnt_q <= to_cnt_q + TCNT_W'(1);
            end
            if (load_freq || to_expire) begin
                lock_cnt_q <= '0;
                locked_q   <= 1'b0;
            end else if (edge_go) begin
                if (in_win) begin
                    if (lock_cnt_q != LCNT_W'(LOCK_N)) begin
                        lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
                    end
                    if (lock_cnt_q >= LCNT_W'(LOCK_N - 1)) begin
                        locked_q <= 1'b1;
                    end
                end else begin
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end
            end
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_swipt_dpll_gen2.sv
// Self-checking bench for swipt_dpll_gen2: directed scenarios plus randomized stimulus
// compared every cycle against an arithmetic reference model.
module tb_swipt_dpll_gen2;

    localparam longint FMIN = 64'h20;
    localparam longint FMAX = 64'h0800_0000;
    localparam longint LTH  = 64'h0100_0000;
    localparam longint HALF = 64'h8000_0000;
    localparam longint FULL = 64'h1_0000_0000;
    localparam int     LN   = 16;
    localparam int     TO   = 4096;
`ifdef SWIPT_DPLL_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst, enable, load_freq, pll_in;
    logic [31:0] freq_init;
    logic [4:0]  lg_p, lg_i;
    logic [31:0] phase, freq;
    logic [1:0]  error;
    logic        edge_valid, locked;

    swipt_dpll_gen2 #(
        .PHASE_W  (32),
        .LG_W     (5),
        .FREQ_MIN (32'h0000_0020),
        .FREQ_MAX (32'h0800_0000),
        .LOCK_TH  (32'h0100_0000),
        .LOCK_N   (16),
        .TIMEOUT  (4096)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .load_freq  (load_freq),
        .freq_init  (freq_init),
        .lg_p       (lg_p),
        .lg_i       (lg_i),
        .pll_in     (pll_in),
        .phase      (phase),
        .freq       (freq),
        .error      (error),
        .edge_valid (edge_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values
    longint m_phase, m_freq, m_integ;
    bit     m_lag, m_ev, m_locked;
    int     m_lcnt, m_since;
    bit     hist [3];   // hist[0] = most recent pll_in sample

    function automatic longint clampf(input longint v);
        if (v < FMIN) return FMIN;
        if (v > FMAX) return FMAX;
        return v;
    endfunction

    task automatic model_step();
        bit     rise;
        longint err, in_n, f_old, mag;
        if (nrst) begin
            m_phase = 0; m_freq = freq_init; m_integ = freq_init;
            m_lag = 0; m_ev = 0; m_locked = 0; m_lcnt = 0; m_since = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
            return;
        end
        rise  = hist[1] && !hist[2];
        err   = (m_phase >= HALF) ? m_phase - FULL : m_phase;
        f_old = m_freq;
        m_ev  = 0;
        if (load_freq) begin
            m_freq = freq_init; m_integ = freq_init; m_lcnt = 0; m_locked = 0;
        end else if (enable && rise) begin
            in_n    = m_integ + (err >>> lg_i);
            m_freq  = clampf(in_n + (err >>> lg_p));
            m_integ = clampf(in_n);
            m_lag   = (err < 0);
            m_ev    = 1;
            mag     = (err < 0) ? -err : err;
            if (err != -HALF && mag < LTH) begin
                if (m_lcnt < LN) m_lcnt++;
                if (m_lcnt == LN) m_locked = 1;
            end else begin
                m_lcnt = 0; m_locked = 0;
            end
        end
        if (rise) m_since = 0;
        else if (enable && m_since < TO) m_since++;
        if (m_since == TO) begin
            m_lcnt = 0; m_locked = 0;
        end
        if (enable) m_phase = (m_phase + f_old) % FULL;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pll_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("phase", phase, m_phase);
        check_eq("freq", freq, m_freq);
        check_eq("error", error, {m_lag, m_phase[31]});
        check_eq("edge_valid", edge_valid, m_ev);
        check_eq("locked", locked, LOCK_EN && m_locked);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n_ev;
        longint sv_phase, sv_freq;

        // Reset
        nrst = 1; enable = 0; load_freq = 0; pll_in = 0;
        freq_init = 32'h9C40; lg_p = 0; lg_i = 0;
        repeat (3) tick();
        check_eq("rst_phase", phase, 0);
        check_eq("rst_freq", freq, 32'h9C40);
        check_eq("rst_error", error, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_ev", edge_valid, 0);
        nrst = 0; enable = 1;
        tick(); check_eq("nco_step1", phase, 32'h9C40);
        tick(); check_eq("nco_step2", phase, 32'h13880);

        // Wrap
        nrst = 1; freq_init = 32'h8000_0000; tick();
        nrst = 0; enable = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wrap_phase", phase, (i % 2 == 0) ? 32'h8000_0000 : 32'h0);
            check_eq("wrap_nco", error[0], (i % 2 == 0) ? 1 : 0);
        end

        // Loop step: edge seen at phase 0x400 with freq 0x1000
        nrst = 1; enable = 0; freq_init = 32'h400; lg_p = 2; lg_i = 4; tick();
        nrst = 0; enable = 1; tick();
        enable = 0; load_freq = 1; freq_init = 32'h1000; tick();
        load_freq = 0;
        check_eq("step_pre_phase", phase, 32'h400);
        pll_in = 1; tick(); tick();
        enable = 1; tick();
        check_eq("step_ev", edge_valid, 1);
        check_eq("step_freq", freq, 32'h1140);
        check_eq("step_lag", error[1], 0);
        enable = 0; tick();
        check_eq("step_ev_once", edge_valid, 0);
        pll_in = 0;

        // Clamp: large negative error with unity gains
        nrst = 1; freq_init = 32'h8000_0001; lg_p = 0; lg_i = 0; tick();
        nrst = 0; enable = 1; tick();
        enable = 0; load_freq = 1; freq_init = 32'h1000; tick();
        load_freq = 0;
        pll_in = 1; tick(); tick();
        enable = 1; tick();
        check_eq("clamp_freq", freq, 32'h20);
        check_eq("clamp_lag", error[1], 1);
        enable = 0; pll_in = 0; tick();

        // Lock: reference aligned to a 64-cycle NCO period, then removed
        nrst = 1; freq_init = 32'h0400_0000; lg_p = 4; lg_i = 4; tick();
        nrst = 0; enable = 1;
        n_ev = 0;
        for (int n = 1; n <= 2000 && n_ev < 16; n++) begin
            pll_in = (n % 64 == 63);
            tick();
            if (edge_valid) begin
                n_ev++;
                check_eq("lock_progress", locked, LOCK_EN && n_ev >= 16);
            end
        end
        check_eq("lock_edges", n_ev, 16);
        pll_in = 0;
        repeat (TO - 1) tick();
        check_eq("lock_hold", locked, LOCK_EN);
        tick();
        check_eq("timeout_unlock", locked, 0);
        check_eq("timeout_freq", freq, 32'h0400_0000);

        // Priority: load_freq beats a coincident edge; enable=0 freezes the loop
        pll_in = 1; tick(); tick();
        load_freq = 1; freq_init = 32'h0300_0000; tick();
        load_freq = 0; pll_in = 0;
        check_eq("prio_freq", freq, 32'h0300_0000);
        check_eq("prio_ev", edge_valid, 0);
        tick();
        check_eq("prio_ev_next", edge_valid, 0);
        enable = 0;
        sv_phase = m_phase; sv_freq = m_freq;
        pll_in = 1;
        repeat (100) tick();
        check_eq("freeze_phase", phase, sv_phase);
        check_eq("freeze_freq", freq, sv_freq);
        check_eq("freeze_ev", edge_valid, 0);
        pll_in = 0;

        // Randomized run against the model
        lg_p = 3; lg_i = 6;
        for (int r = 0; r < 3000; r++) begin
            nrst      = ($urandom_range(0, 499) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            load_freq = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) begin
                freq_init = $urandom_range(32'(FMIN), 32'(FMAX));
                lg_p = 5'($urandom);
                lg_i = 5'($urandom);
            end
            if ($urandom_range(0, 15) == 0) pll_in = ~pll_in;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
